// File: rtl/voice_div_scheduler.sv
// voice_div_scheduler: time-shares one sequential divider across NVOICE oscillator voices per sample tick
module voice_div_scheduler #(
    parameter int NVOICE   = 4,
    parameter int CNT_W    = 16,
    parameter int Q_W      = 8,
    parameter int WAIT_MAX = 63
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample_tick,
    input  logic [NVOICE-1:0]       voice_en,
    input  logic [NVOICE*CNT_W-1:0] count_i,
    input  logic [NVOICE*CNT_W-1:0] divider_i,
    output logic                    div_load_o,
    output logic [CNT_W-1:0]        div_dividend_o,
    output logic [CNT_W-1:0]        div_divisor_o,
    input  logic                    div_done_i,
    input  logic [Q_W-1:0]          div_quotient_i,
    output logic [NVOICE*Q_W-1:0]   sample_o,
    output logic                    sample_valid_o,
    output logic                    busy_o,
    output logic                    overrun_o,
    output logic                    timeout_o
);
    localparam int IW = NVOICE > 1 ? $clog2(NVOICE) : 1;
    localparam int TW = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {IDLE, EVAL, LOAD, WAIT, DONE} state_t;
    state_t state, state_n;

    logic [IW-1:0]    idx;
    logic [TW-1:0]    timer;
    logic [CNT_W-1:0] cnt, dvs;
    logic [Q_W-1:0]   wr_val;
    logic             last, wr, adv, to;

    assign cnt            = count_i[idx*CNT_W +: CNT_W];
    assign dvs            = divider_i[idx*CNT_W +: CNT_W];
    assign last           = idx == IW'(NVOICE - 1);
    assign div_load_o     = state == LOAD;
    assign sample_valid_o = state == DONE;
    assign busy_o         = state != IDLE;

    always_comb begin
        state_n = state;
        wr      = 1'b0;
        wr_val  = '0;
        adv     = 1'b0;
        to      = 1'b0;
        case (state)
            IDLE: state_n = sample_tick ? EVAL : IDLE;
            EVAL: begin
                if (!voice_en[idx] || dvs == '0) begin
                    wr  = 1'b1;
                    adv = 1'b1;
                end else if (cnt >= dvs) begin
                    wr     = 1'b1;
                    wr_val = '1;
                    adv    = 1'b1;
                end else begin
                    state_n = LOAD;
                end
            end
            LOAD: state_n = WAIT;
            WAIT: begin
                if (div_done_i) begin
                    wr     = 1'b1;
                    wr_val = div_quotient_i;
                    adv    = 1'b1;
                end else if (timer == TW'(WAIT_MAX - 1)) begin
                    wr  = 1'b1;
                    adv = 1'b1;
                    to  = 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (adv) state_n = last ? DONE : EVAL;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx            <= '0;
            timer          <= '0;
            sample_o       <= '0;
            div_dividend_o <= '0;
            div_divisor_o  <= '0;
            overrun_o      <= 1'b0;
            timeout_o      <= 1'b0;
        end else begin
            overrun_o <= sample_tick && state != IDLE;
            timeout_o <= to;
            if (state == IDLE && sample_tick) idx <= '0;
            if (state == EVAL && state_n == LOAD) begin
                div_dividend_o <= cnt;
                div_divisor_o  <= dvs;
            end
            if (state == LOAD)      timer <= '0;
            else if (state == WAIT) timer <= timer + TW'(1);
            if (wr) sample_o[idx*Q_W +: Q_W] <= wr_val;
            if (adv && !last) idx <= idx + IW'(1);
        end
    end
endmodule
